// File: rtl/mc_core_ctrl.sv
// Sequencing controller for the multi-cycle core: owns pc/ir and walks
// IF/ID/EXE/MEM/WB over req/addr_ok/data_ok buses with a handshake watchdog.
module mc_core_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             resetn,
   output logic             inst_req,
   output logic [31:0]      inst_addr,
   input  logic             inst_addr_ok,
   input  logic             inst_data_ok,
   input  logic [31:0]      inst_rdata,
   output logic             data_req,
   output logic             data_wr,
   input  logic             data_addr_ok,
   input  logic             data_data_ok,
   input  logic             dec_mem_rd,
   input  logic             dec_mem_wr,
   input  logic             dec_wb,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   output logic [31:0]      pc,
   output logic [31:0]      ir,
   output logic [2:0]       state,
   output logic             rf_we,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [1:0]       err
);

   typedef enum logic [2:0] {
      IF_REQ   = 3'd0,
      IF_WAIT  = 3'd1,
      ID       = 3'd2,
      EXE      = 3'd3,
      MEM_REQ  = 3'd4,
      MEM_WAIT = 3'd5,
      WB       = 3'd6,
      HALT     = 3'd7
   } state_t;

   localparam logic [31:0] TO_LIM = 32'(TIMEOUT);
   localparam bit          WD_EN  = (TIMEOUT != 0);

   state_t      cur;
   state_t      nxt;
   logic [31:0] wd;
   logic        wr_q;
   logic        retire;
   logic        waiting;
   logic        misalign;
   logic        wd_hit;

   assign misalign = br_taken && (br_target[1:0] != '0);
   assign wd_hit   = WD_EN && (wd == TO_LIM - 32'd1);

   always_comb begin
      nxt     = cur;
      retire  = 1'b0;
      waiting = 1'b0;
      case (cur)
         IF_REQ: begin
            if (inst_addr_ok) nxt = IF_WAIT;
            else              waiting = 1'b1;
         end
         IF_WAIT: begin
            if (inst_data_ok) nxt = ID;
            else              waiting = 1'b1;
         end
         ID: nxt = EXE;
         EXE: begin
            if (dec_mem_rd || dec_mem_wr) nxt = MEM_REQ;
            else if (dec_wb)              nxt = WB;
            else                          retire = 1'b1;
         end
         MEM_REQ: begin
            if (data_addr_ok) nxt = MEM_WAIT;
            else              waiting = 1'b1;
         end
         MEM_WAIT: begin
            if (data_data_ok) begin
               if (dec_mem_rd) nxt = WB;
               else            retire = 1'b1;
            end else begin
               waiting = 1'b1;
            end
         end
         WB:      retire = 1'b1;
         HALT:    nxt = HALT;
         default: nxt = HALT;
      endcase
      // A misaligned taken target stops the core instead of retiring.
      if (retire)            nxt = misalign ? HALT : IF_REQ;
      if (waiting && wd_hit) nxt = HALT;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur        <= IF_REQ;
         pc         <= RESET_PC;
         ir         <= '0;
         retire_cnt <= '0;
         err        <= '0;
         wd         <= '0;
         wr_q       <= 1'b0;
      end else begin
         cur <= nxt;
         if (nxt != cur)   wd <= '0;
         else if (waiting) wd <= wd + 32'd1;
         if (cur == IF_WAIT && inst_data_ok) ir <= inst_rdata;
         // Latch the store flag so data_wr depends on registered state only.
         if (cur == EXE) wr_q <= dec_mem_wr;
         if (retire && !misalign) begin
            pc         <= br_taken ? br_target : pc + 32'd4;
            retire_cnt <= retire_cnt + CNT_W'(1);
         end
         if (retire && misalign) err <= 2'b10;
         if (waiting && wd_hit)  err <= 2'b01;
      end
   end

   assign state     = cur;
   assign inst_req  = (cur == IF_REQ);
   assign inst_addr = pc;
   assign data_req  = (cur == MEM_REQ);
   assign data_wr   = (cur == MEM_REQ) && wr_q;
   assign rf_we     = (cur == WB);

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Randomized bench for mc_core_ctrl: a per-instruction schedule model
// predicts every cycle's state and outputs plus pc/retire_cnt/err.
module tb_mc_core_ctrl;
   localparam logic [31:0] RPC = 32'h1c00_0000;
   localparam int          TO  = 4;
   localparam int          CW  = 4;
   localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic          inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0]   inst_addr, inst_rdata;
   logic          data_req, data_wr, data_addr_ok, data_data_ok;
   logic          dec_mem_rd, dec_mem_wr, dec_wb, br_taken;
   logic [31:0]   br_target, pc, ir;
   logic [2:0]    state;
   logic          rf_we;
   logic [CW-1:0] retire_cnt;
   logic [1:0]    err;

   mc_core_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_wb(dec_wb),
      .br_taken(br_taken), .br_target(br_target),
      .pc(pc), .ir(ir), .state(state), .rf_we(rf_we),
      .retire_cnt(retire_cnt), .err(err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_pc;
   int          m_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic noise();
      inst_addr_ok = 1'($urandom_range(0, 1));
      inst_data_ok = 1'($urandom_range(0, 1));
      data_addr_ok = 1'($urandom_range(0, 1));
      data_data_ok = 1'($urandom_range(0, 1));
      inst_rdata   = $urandom;
   endtask

   // Entered at posedge+1; releases reset at posedge+1 of the next cycle.
   task automatic do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_pc", 64'(pc), 64'(RPC));
      chk("rst_ir", 64'(ir), 64'd0);
      chk("rst_cnt", 64'(retire_cnt), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_req", 64'({data_req, rf_we}), 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      m_pc  = RPC;
      m_cnt = 0;
   endtask

   task automatic halt_check(input logic [1:0] e);
      repeat (3) begin
         noise();
         chk("halt_state", 64'(state), 64'd7);
         chk("halt_outs", 64'({inst_req, data_req, data_wr, rf_we, err}), 64'({4'b0000, e}));
         chk("halt_pc", 64'(pc), 64'(m_pc));
         chk("halt_cnt", 64'(retire_cnt), 64'(m_cnt));
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   // One instruction: d0..d3 are wait cycles on inst addr/data, data addr/data.
   task automatic run_instr(input int cls, input int d0, input int d1, input int d2, input int d3,
                            input bit taken, input logic [31:0] tgt, input bit rst_mw);
      int          st_q[$];
      bit          hs_q[$];
      int          wst[4];
      int          dl[4];
      int          nw;
      int          s;
      bit          h;
      bit          to;
      bit          mem;
      bit          wb;
      logic [31:0] word;
      wst = '{0, 1, 4, 5};
      dl  = '{d0, d1, d2, d3};
      mem = (cls == C_LD) || (cls == C_ST);
      wb  = (cls == C_ALU) || (cls == C_LD);
      nw  = mem ? 4 : 2;
      to  = 1'b0;
      word = $urandom;
      dec_mem_rd = (cls == C_LD);
      dec_mem_wr = (cls == C_ST);
      dec_wb     = wb;
      br_taken   = taken;
      br_target  = tgt;
      for (int w = 0; w < nw && !to; w++) begin
         if (dl[w] >= TO) begin
            repeat (TO) begin st_q.push_back(wst[w]); hs_q.push_back(1'b0); end
            to = 1'b1;
         end else begin
            repeat (dl[w]) begin st_q.push_back(wst[w]); hs_q.push_back(1'b0); end
            st_q.push_back(wst[w]); hs_q.push_back(1'b1);
         end
         if (w == 1 && !to) begin
            st_q.push_back(2); hs_q.push_back(1'b0);
            st_q.push_back(3); hs_q.push_back(1'b0);
         end
      end
      if (!to && (cls == C_LD || (!mem && wb))) begin st_q.push_back(6); hs_q.push_back(1'b0); end

      for (int i = 0; i < st_q.size(); i++) begin
         s = st_q[i];
         h = hs_q[i];
         noise();
         case (s)
            0: inst_addr_ok = h;
            1: begin inst_data_ok = h; if (h) inst_rdata = word; end
            4: data_addr_ok = h;
            5: data_data_ok = h;
            default: ;
         endcase
         chk("state", 64'(state), 64'(s));
         chk("outs", 64'({inst_req, data_req, data_wr, rf_we, err}),
             64'({s == 0, s == 4, (s == 4) && (cls == C_ST), s == 6, 2'b00}));
         if (i == 0) begin
            chk("inst_addr", 64'(inst_addr), 64'(m_pc));
            chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
         end
         if (s == 2) chk("ir", 64'(ir), 64'(word));
         if (s == 5 && rst_mw) begin
            #2;
            do_reset();
            return;
         end
         @(posedge clk); #1;
      end

      if (to) begin
         halt_check(2'b01);
      end else if (taken && tgt[1:0] != 2'b00) begin
         halt_check(2'b10);
      end else begin
         m_pc  = taken ? tgt : m_pc + 32'd4;
         m_cnt = (m_cnt + 1) % (1 << CW);
      end
   endtask

   function automatic int rnd_delay();
      return ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, 3);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got 0 exp 1");
      $fatal(1, "bench time limit expired");
   end

   initial begin
      int          cls;
      bit          tk;
      logic [31:0] tg;
      resetn = 1'b0;
      {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} = '0;
      {dec_mem_rd, dec_mem_wr, dec_wb, br_taken} = '0;
      inst_rdata = '0;
      br_target  = '0;
      m_pc  = RPC;
      m_cnt = 0;
      @(posedge clk); #1;
      do_reset();

      run_instr(C_ALU, 0, 0, 0, 0, 0, 32'h0, 0);
      run_instr(C_LD, 0, 3, 0, 3, 0, 32'h0, 0);
      run_instr(C_BR, 0, 0, 0, 0, 1, 32'h1c00_0100, 0);
      run_instr(C_ALU, 0, 0, 0, 0, 0, 32'h0, 0);
      run_instr(C_BR, 0, 0, 0, 0, 1, 32'h1c00_0102, 0);
      run_instr(C_ALU, 9, 0, 0, 0, 0, 32'h0, 0);
      run_instr(C_ST, 0, 0, 0, 9, 0, 32'h0, 0);
      run_instr(C_ALU, 1, 1, 0, 0, 0, 32'h0, 0);
      run_instr(C_ST, 1, 0, 1, 2, 0, 32'h0, 1);
      run_instr(C_ALU, 0, 0, 0, 0, 0, 32'h0, 0);
      do_reset();
      repeat (17) run_instr(C_ALU, 0, 0, 0, 0, 0, 32'h0, 0);
      run_instr(C_ALU, 0, 0, 0, 0, 1, 32'hffff_fffc, 0);
      run_instr(C_ALU, 0, 0, 0, 0, 0, 32'h0, 0);

      repeat (80) begin
         cls = $urandom_range(0, 3);
         tk  = (cls < 2) && ($urandom_range(0, 1) == 1);
         tg  = $urandom & 32'hffff_fffc;
         if ($urandom_range(0, 11) == 0) tg[1:0] = 2'($urandom_range(1, 3));
         run_instr(cls, rnd_delay(), rnd_delay(), rnd_delay(), rnd_delay(), tk, tg,
                   (cls >= 2) && ($urandom_range(0, 15) == 0));
      end

      noise();
      chk("final_state", 64'(state), 64'd0);
      chk("final_pc", 64'(pc), 64'(m_pc));
      chk("final_cnt", 64'(retire_cnt), 64'(m_cnt));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
